// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller.
// Holds the scan state enum and the slot-length helper.
package fnd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    function automatic int digit_cyc(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

endpackage

// File: rtl/fnd_slot_timer.sv
// Modulo-MOD counter with clear, enable, terminal-count and compare flags.
// Used for both the digit slot timer and the half-second blink timer.
module fnd_slot_timer #(
    parameter int MOD = 10,
    parameter int CMP = 0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc,
    output logic o_cmp
);

    localparam int W = (MOD > 1) ? $clog2(MOD) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= o_tc ? '0 : cnt + 1'b1;
        end
    end

    assign o_tc  = (cnt == W'(MOD - 1));
    assign o_cmp = (cnt == W'(CMP));

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit common-anode FND scan controller with per-slot blanking.
// Optional DP blink when FND_DP_BLINK_EN is defined.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 1000,
    parameter int DP_DIGIT  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic                  i_page,
    output logic [2:0]            o_sel,
    output logic [NUM_DIGITS-1:0] o_an,
    output logic                  o_dp,
    output logic                  o_frame_tick
);

    localparam int DIGIT_CYC = digit_cyc(CLK_HZ, SCAN_HZ);

    if (BLANK_CYC < 1 || BLANK_CYC >= DIGIT_CYC) begin : g_bad_blank
        $error("BLANK_CYC must satisfy 1 <= BLANK_CYC < DIGIT_CYC");
    end
    if (DP_DIGIT < 0 || DP_DIGIT >= NUM_DIGITS) begin : g_bad_dp
        $error("DP_DIGIT must be 0..3");
    end

    state_t     state;
    logic [1:0] digit;
    logic [1:0] digit_nx;
    logic       page_q;
    logic       blank_end;
    logic       slot_end;
    logic       dp_lit;

    assign digit_nx = digit + 2'd1;

    // Slot counter is held at zero whenever the scan is stopped
    fnd_slot_timer #(
        .MOD(DIGIT_CYC),
        .CMP(BLANK_CYC - 1)
    ) u_slot (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_clr  ((state == IDLE) || !i_en),
        .i_en   (state != IDLE),
        .o_tc   (slot_end),
        .o_cmp  (blank_end)
    );

`ifdef FND_DP_BLINK_EN
    localparam logic [1:0] DP_SEL = 2'(DP_DIGIT);

    logic blink_q;
    logic blink_tc;
    logic blink_cmp;

    fnd_slot_timer #(
        .MOD(CLK_HZ / 2),
        .CMP(CLK_HZ / 2 - 1)
    ) u_blink (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_clr  (1'b0),
        .i_en   (i_en),
        .o_tc   (blink_tc),
        .o_cmp  (blink_cmp)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            blink_q <= 1'b0;
        end else if (i_en && blink_tc && blink_cmp) begin
            blink_q <= ~blink_q;
        end
    end

    assign dp_lit = blink_q && (digit == DP_SEL);
`else
    assign dp_lit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            digit        <= 2'd0;
            page_q       <= 1'b0;
            o_sel        <= 3'b000;
            o_an         <= AN_OFF;
            o_dp         <= 1'b1;
            o_frame_tick <= 1'b0;
        end else if (!i_en) begin
            state        <= IDLE;
            digit        <= 2'd0;
            o_sel        <= {page_q, 2'b00};
            o_an         <= AN_OFF;
            o_dp         <= 1'b1;
            o_frame_tick <= 1'b0;
        end else begin
            o_frame_tick <= 1'b0;
            unique case (state)
                IDLE: begin
                    state  <= BLANK;
                    digit  <= 2'd0;
                    page_q <= i_page;
                    o_sel  <= {i_page, 2'b00};
                    o_an   <= AN_OFF;
                    o_dp   <= 1'b1;
                end
                BLANK: begin
                    if (blank_end) begin
                        state <= DRIVE;
                        o_an  <= ~(4'b0001 << digit);
                        o_dp  <= ~dp_lit;
                    end
                end
                DRIVE: begin
                    if (slot_end) begin
                        state <= BLANK;
                        digit <= digit_nx;
                        o_an  <= AN_OFF;
                        o_dp  <= 1'b1;
                        // Page is only sampled at the frame wrap
                        if (digit == 2'd3) begin
                            page_q       <= i_page;
                            o_sel        <= {i_page, 2'b00};
                            o_frame_tick <= 1'b1;
                        end else begin
                            o_sel <= {page_q, digit_nx};
                        end
                    end else begin
                        o_dp <= ~dp_lit;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
